// File: rtl/instruction_decode_buffer.sv
// Fetch-pair instruction FIFO with RV32I field/type decode of the head entry.
// Optional macro DECODE_IMM_EN enables immediate generation on o_dec_imm.
module instruction_decode_buffer #(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_in_valid,
   input  logic [31:0] i_in_instr1,
   input  logic [31:0] i_in_instr2,
   input  logic        i_out_ready,
   output logic        o_fetch_stall,
   output logic        o_overflow,
   output logic        o_dec_valid,
   output logic [31:0] o_dec_instr,
   output logic [31:0] o_dec_imm,
   output logic [6:0]  o_dec_opcode,
   output logic [6:0]  o_dec_funct7,
   output logic [4:0]  o_dec_rd,
   output logic [4:0]  o_dec_rs1,
   output logic [4:0]  o_dec_rs2,
   output logic [2:0]  o_dec_funct3,
   output logic [2:0]  o_dec_type,
   output logic        o_dec_illegal,
   output logic [31:0] o_dec_index
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 4");
   end

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [31:0]   r_index;

   logic          w_v1, w_v2, w_drop, w_wr1, w_wr2, w_pop;
   logic [1:0]    w_nwr, w_nacc;
   logic [CW-1:0] w_free;
   logic [AW-1:0] w_wptr2;

   assign w_v1    = i_in_valid & (|i_in_instr1);
   assign w_v2    = i_in_valid & (|i_in_instr2);
   assign w_nwr   = {1'b0, w_v1} + {1'b0, w_v2};
   // Capacity uses pre-edge occupancy; a same-cycle pop is not credited.
   assign w_free  = CW'(DEPTH) - r_count;
   assign w_drop  = i_in_valid && (CW'(w_nwr) > w_free);
   assign w_wr1   = w_v1 & ~w_drop;
   assign w_wr2   = w_v2 & ~w_drop;
   assign w_nacc  = w_drop ? 2'd0 : w_nwr;
   assign w_wptr2 = r_wptr + AW'(w_wr1);
   assign w_pop   = o_dec_valid & i_out_ready;

   assign o_dec_valid   = (r_count != '0);
   assign o_fetch_stall = (w_free < CW'(2));
   assign o_overflow    = r_overflow;
   assign o_dec_index   = r_index;

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_wr1) r_mem[r_wptr]  <= i_in_instr1;
         if (w_wr2) r_mem[w_wptr2] <= i_in_instr2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_index    <= '0;
      end else begin
         r_wptr  <= r_wptr + AW'(w_nacc);
         r_count <= r_count + CW'(w_nacc) - CW'(w_pop);
         if (w_drop) r_overflow <= 1'b1;
         if (w_pop) begin
            r_rptr  <= r_rptr + AW'(1);
            r_index <= r_index + 32'd1;
         end
      end
   end

   logic [31:0] w_head;
   logic [2:0]  w_type;
   logic [31:0] w_imm;

   // Gate the head word so every decoded field reads zero while empty.
   assign w_head = o_dec_valid ? r_mem[r_rptr] : 32'h0;

   always_comb begin
      w_type = 3'd7;
      case (w_head[6:0])
         7'b0110011:                         w_type = 3'd0;
         7'b0010011, 7'b0000011, 7'b1100111: w_type = 3'd1;
         7'b0100011:                         w_type = 3'd2;
         7'b1100011:                         w_type = 3'd3;
         7'b0110111, 7'b0010111:             w_type = 3'd4;
         7'b1101111:                         w_type = 3'd5;
         default:                            w_type = 3'd7;
      endcase
      if (!o_dec_valid) w_type = 3'd0;
   end

`ifdef DECODE_IMM_EN
   always_comb begin
      w_imm = 32'h0;
      case (w_type)
         3'd1: w_imm = {{20{w_head[31]}}, w_head[31:20]};
         3'd2: w_imm = {{20{w_head[31]}}, w_head[31:25], w_head[11:7]};
         3'd3: w_imm = {{19{w_head[31]}}, w_head[31], w_head[7], w_head[30:25],
                        w_head[11:8], 1'b0};
         3'd4: w_imm = {w_head[31:12], 12'b0};
         3'd5: w_imm = {{11{w_head[31]}}, w_head[31], w_head[19:12], w_head[20],
                        w_head[30:21], 1'b0};
         default: w_imm = 32'h0;
      endcase
   end
`else
   assign w_imm = 32'h0;
`endif

   assign o_dec_instr   = w_head;
   assign o_dec_imm     = w_imm;
   assign o_dec_opcode  = w_head[6:0];
   assign o_dec_rd      = w_head[11:7];
   assign o_dec_funct3  = w_head[14:12];
   assign o_dec_rs1     = w_head[19:15];
   assign o_dec_rs2     = w_head[24:20];
   assign o_dec_funct7  = w_head[31:25];
   assign o_dec_type    = w_type;
   assign o_dec_illegal = (w_type == 3'd7);

endmodule

// File: tb/tb_instruction_decode_buffer.sv
// Directed bench for instruction_decode_buffer: queue scoreboard of accepted
// words plus an independent RV32I decode model for the head outputs.
module tb_instruction_decode_buffer;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_in_valid, i_out_ready;
   logic [31:0] i_in_instr1, i_in_instr2;
   logic        o_fetch_stall, o_overflow, o_dec_valid, o_dec_illegal;
   logic [31:0] o_dec_instr, o_dec_imm, o_dec_index;
   logic [6:0]  o_dec_opcode, o_dec_funct7;
   logic [4:0]  o_dec_rd, o_dec_rs1, o_dec_rs2;
   logic [2:0]  o_dec_funct3, o_dec_type;

   instruction_decode_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .i_in_valid(i_in_valid),
      .i_in_instr1(i_in_instr1), .i_in_instr2(i_in_instr2),
      .i_out_ready(i_out_ready), .o_fetch_stall(o_fetch_stall),
      .o_overflow(o_overflow), .o_dec_valid(o_dec_valid),
      .o_dec_instr(o_dec_instr), .o_dec_imm(o_dec_imm),
      .o_dec_opcode(o_dec_opcode), .o_dec_funct7(o_dec_funct7),
      .o_dec_rd(o_dec_rd), .o_dec_rs1(o_dec_rs1), .o_dec_rs2(o_dec_rs2),
      .o_dec_funct3(o_dec_funct3), .o_dec_type(o_dec_type),
      .o_dec_illegal(o_dec_illegal), .o_dec_index(o_dec_index)
   );

   always #5 clk = ~clk;

   int passed = 0, total = 0, fails = 0;
   logic [31:0] mq[$];
   logic        m_ovf;
   logic [31:0] m_idx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] m_type(input logic [31:0] w);
      case (w[6:0])
         7'h33:               return 3'd0;
         7'h13, 7'h03, 7'h67: return 3'd1;
         7'h23:               return 3'd2;
         7'h63:               return 3'd3;
         7'h37, 7'h17:        return 3'd4;
         7'h6F:               return 3'd5;
         default:             return 3'd7;
      endcase
   endfunction

   function automatic logic [31:0] m_imm(input logic [31:0] w);
`ifdef DECODE_IMM_EN
      int s;
      s = int'(w);
      case (m_type(w))
         3'd1: return 32'(s >>> 20);
         3'd2: return (32'(s >>> 25) << 5) | 32'(w[11:7]);
         3'd3: return (32'(s >>> 31) << 12) | (32'(w[7]) << 11) |
                      (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
         3'd4: return w & 32'hFFFF_F000;
         3'd5: return (32'(s >>> 31) << 20) | (32'(w[19:12]) << 12) |
                      (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
         default: return 32'h0;
      endcase
`else
      return (w == w) ? 32'h0 : 32'h0;
`endif
   endfunction

   task automatic chk_head();
      logic [31:0] w;
      w = (mq.size() != 0) ? mq[0] : 32'h0;
      chk("dec_valid", 32'(o_dec_valid), 32'(mq.size() != 0));
      chk("dec_instr", o_dec_instr, w);
      chk("dec_opcode", 32'(o_dec_opcode), 32'(w & 32'h7F));
      chk("dec_rd", 32'(o_dec_rd), (w >> 7) & 32'h1F);
      chk("dec_funct3", 32'(o_dec_funct3), (w >> 12) & 32'h7);
      chk("dec_rs1", 32'(o_dec_rs1), (w >> 15) & 32'h1F);
      chk("dec_rs2", 32'(o_dec_rs2), (w >> 20) & 32'h1F);
      chk("dec_funct7", 32'(o_dec_funct7), w >> 25);
      chk("dec_type", 32'(o_dec_type), (mq.size() != 0) ? 32'(m_type(w)) : 32'h0);
      chk("dec_illegal", 32'(o_dec_illegal), 32'((mq.size() != 0) && (m_type(w) == 3'd7)));
      chk("dec_imm", o_dec_imm, (mq.size() != 0) ? m_imm(w) : 32'h0);
   endtask

   // One clock: drive at negedge, check head, update scoreboard, check state after edge.
   task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b, input logic rdy);
      int n, free;
      @(negedge clk);
      i_in_valid = v; i_in_instr1 = a; i_in_instr2 = b; i_out_ready = rdy;
      #1;
      chk_head();
      free = DEPTH - mq.size();
      n = int'(v && a != 0) + int'(v && b != 0);
      if (rdy && mq.size() != 0) begin
         void'(mq.pop_front());
         m_idx++;
      end
      if (v) begin
         if (n > free) m_ovf = 1'b1;
         else begin
            if (a != 0) mq.push_back(a);
            if (b != 0) mq.push_back(b);
         end
      end
      @(posedge clk);
      #1;
      chk("dec_valid_post", 32'(o_dec_valid), 32'(mq.size() != 0));
      chk("fetch_stall", 32'(o_fetch_stall), 32'((DEPTH - mq.size()) < 2));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("dec_index", o_dec_index, m_idx);
   endtask

   initial begin
      reset = 1'b1; i_in_valid = 0; i_in_instr1 = 0; i_in_instr2 = 0; i_out_ready = 0;
      m_ovf = 0; m_idx = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(o_dec_valid), 32'h0);
      chk("rst_stall", 32'(o_fetch_stall), 32'h0);
      chk("rst_ovf", 32'(o_overflow), 32'h0);
      chk("rst_index", o_dec_index, 32'h0);
      chk("rst_type", 32'(o_dec_type), 32'h0);
      @(negedge clk); reset = 1'b0;

      // addi x1,x0,5 alone, then pop
      step(1, 32'h0050_0093, 32'h0, 0);
      chk("r33_type", 32'(o_dec_type), 32'd1);
      chk("r33_rd", 32'(o_dec_rd), 32'd1);
`ifdef DECODE_IMM_EN
      chk("r33_imm", o_dec_imm, 32'd5);
`endif
      step(0, 32'h0, 32'h0, 1);
      chk("r33_idx", o_dec_index, 32'd1);
      chk("r33_valid", 32'(o_dec_valid), 32'd0);
      step(1, 32'h0, 32'h0, 1);   // all-zero pair writes nothing

      // negative I immediate then B immediate, streaming
      step(1, 32'hFFF0_0093, 32'hFE00_0EE3, 1);
`ifdef DECODE_IMM_EN
      chk("r34_imm_i", o_dec_imm, 32'hFFFF_FFFF);
`endif
      chk("r34_type_i", 32'(o_dec_type), 32'd1);
      step(0, 32'h0, 32'h0, 1);
`ifdef DECODE_IMM_EN
      chk("r34_imm_b", o_dec_imm, 32'hFFFF_FFFC);
`endif
      chk("r34_type_b", 32'(o_dec_type), 32'd3);
      step(0, 32'h0, 32'h0, 1);

      // fill to capacity, overflow, drain in order
      step(1, 32'h0020_81B3, 32'h00C1_2223, 0);
      step(1, 32'h1234_52B7, 32'h8000_006F, 0);
      step(1, 32'h0000_0297, 32'hFE20_8AE3, 0);
      step(1, 32'h0040_0067, 32'h0080_2303, 0);
      chk("r35_stall", 32'(o_fetch_stall), 32'd1);
      step(1, 32'h0010_0113, 32'h0020_0193, 0);
      chk("r35_ovf", 32'(o_overflow), 32'd1);
      repeat (9) step(0, 32'h0, 32'h0, 1);
      chk("r35_idx", o_dec_index, 32'd11);

      // simultaneous push+pop with two writes
      step(1, 32'h0030_0213, 32'h0, 0);
      step(1, 32'h0040_0293, 32'h0050_0313, 1);

      // count 7, pair dropped while one pops
      step(1, 32'h0060_0393, 32'h0070_0413, 0);
      step(1, 32'h0080_0493, 32'h0090_0513, 0);
      step(1, 32'h00A0_0593, 32'h0, 0);
      step(1, 32'h00B0_0613, 32'h00C0_0693, 1);
      repeat (7) step(0, 32'h0, 32'h0, 1);

      // illegal all-ones word
      step(1, 32'hFFFF_FFFF, 32'h0, 0);
      chk("r37_type", 32'(o_dec_type), 32'd7);
      chk("r37_ill", 32'(o_dec_illegal), 32'd1);
      chk("r37_imm", o_dec_imm, 32'h0);
      step(0, 32'h0, 32'h0, 1);

      // async reset mid-operation with five entries
      step(1, 32'h0010_0713, 32'h0020_0793, 0);
      step(1, 32'h0030_0813, 32'h0040_0893, 0);
      step(1, 32'h0050_0913, 32'h0, 0);
      @(negedge clk);
      i_in_valid = 0; i_out_ready = 1;
      #2 reset = 1'b1;
      #1;
      chk("r38_valid", 32'(o_dec_valid), 32'd0);
      chk("r38_idx", o_dec_index, 32'd0);
      chk("r38_ovf", 32'(o_overflow), 32'd0);
      chk("r38_instr", o_dec_instr, 32'h0);
      mq.delete(); m_ovf = 0; m_idx = 0;
      @(posedge clk);
      @(negedge clk); reset = 1'b0;
      step(1, 32'h0050_0093, 32'h0, 0);
      chk("r38_type", 32'(o_dec_type), 32'd1);
      step(0, 32'h0, 32'h0, 1);
      chk("r38_idx1", o_dec_index, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/instruction_decode_buffer.md
INSTRUCTION_DECODE_BUFFER -- requirements
Module: instruction_decode_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, minimum 4.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  fetch pair valid, sampled every edge; no backpressure on the fetch side.
REQ-005 in_instr1  input  32  first fetched word, big-endian assembled.
REQ-006 in_instr2  input  32  second fetched word; 32'h0 means NOP or empty slot.
REQ-007 out_ready  input  1  downstream accepts the head instruction this cycle.
REQ-008 fetch_stall  output  1  advisory: fewer than 2 free entries.
REQ-009 overflow  output  1  sticky; a pair was dropped.
REQ-010 dec_valid  output  1  head entry present.
REQ-011 dec_instr, dec_imm  output  32 each  raw head word; decoded immediate.
REQ-012 dec_opcode/dec_funct7 (7), dec_rd/dec_rs1/dec_rs2 (5), dec_funct3 (3)  output  head fields.
REQ-013 dec_type  output  3  R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-014 dec_illegal  output  1  dec_type==7.
REQ-015 dec_index  output  32  count of instructions popped since reset.

Function
REQ-016 Enqueue on edge with in_valid=1: each of instr1 then instr2 in order, skipping any word equal to 32'h0; write count SHALL be 0, 1 or 2.
REQ-017 Capacity check SHALL use pre-edge free = DEPTH-count; a same-cycle pop SHALL NOT be credited.
REQ-018 If write count > free, both words SHALL be dropped, overflow SHALL set, and no partial write SHALL occur.
REQ-019 Pop SHALL occur on an edge with dec_valid=1 and out_ready=1; head advances 1, dec_index increments by 1 and wraps at 2^32.
REQ-020 Simultaneous push and pop SHALL update count by (writes - 1).
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; count width SHALL be log2(DEPTH)+1.
REQ-022 dec_valid SHALL be (count != 0); fetch_stall SHALL be (DEPTH-count < 2); both are combinational from registered state.
REQ-023 Latency: a word written at edge N SHALL appear on dec_* outputs after edge N when the FIFO was empty.
REQ-024 Field slices: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-025 Type decode: 0110011 is R; 0010011, 0000011 and 1100111 are I; 0100011 is S; 1100011 is B; 0110111 and 0010111 are U; 1101111 is J; all others are illegal.
REQ-026 Immediates SHALL follow RV32I encoding: I, S, B and J sign-extended from bit 31; U is {instr[31:12], 12'b0}; R and illegal give 0.
REQ-027 With dec_valid=0, all dec_* outputs except dec_index SHALL be 0.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 Reset SHALL clear pointers, count, overflow and dec_index immediately, including mid-operation; buffered entries SHALL be discarded.
REQ-030 After reset, dec_valid=0, fetch_stall=0, overflow=0, dec_index=0 and all dec_* outputs are 0.
REQ-031 Push and pop are ignored while reset is high.

Configuration
REQ-032 Macro DECODE_IMM_EN: defined builds immediate generation per REQ-026; undefined ties dec_imm to 32'h0, and all other outputs are unchanged.

Verification
REQ-033 Empty FIFO, in_valid with 0x00500093 / 0x00000000 -> one entry; next cycle dec_type=1, dec_rd=1, dec_imm=5; pop -> dec_index=1, dec_valid=0.
REQ-034 in_valid with 0xFFF00093 / 0xFE000EE3, out_ready=1 -> cycle 1: dec_imm=0xFFFFFFFF, type I; cycle 2: dec_imm=0xFFFFFFFC, type B.
REQ-035 DEPTH=8, out_ready=0, four nonzero pairs -> count 8, fetch_stall=1 after the 4th; a 5th pair is dropped and overflow=1; draining yields exactly 8 words in order.
REQ-036 count=7, out_ready=1, push nonzero pair -> pair dropped (free 1 < 2), overflow=1, one pop occurs, count=6.
REQ-037 0xFFFFFFFF enqueued -> dec_type=7, dec_illegal=1, dec_imm=0.
REQ-038 Reset asserted with count=5 -> dec_valid=0 and dec_index=0 without a clock edge; a post-reset push behaves per REQ-033.
